// File: rtl/ibex_pkg.sv
// Shared core types for PC selection and the redirect controller.
// Holds fetch-mux selector enums, exception cause type and redirect FSM encodings.
// No logic here; types and constants only.
package ibex_pkg;

    // Fetch address source selector
    typedef enum logic [2:0] {
        PC_BOOT = 3'd0,
        PC_JUMP = 3'd1,
        PC_EXC  = 3'd2,
        PC_ERET = 3'd3,
        PC_DRET = 3'd4,
        PC_BP   = 3'd5
    } pc_sel_e;

    // Exception vector selector
    typedef enum logic [1:0] {
        EXC_PC_EXC     = 2'd0,
        EXC_PC_IRQ     = 2'd1,
        EXC_PC_DBD     = 2'd2,
        EXC_PC_DBG_EXC = 2'd3
    } exc_pc_sel_e;

    typedef logic [6:0] exc_cause_t;

    // Redirect sequencer states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } redir_state_e;

    // Bit positions of the one-hot grant vector; higher index = higher priority
    typedef enum logic [2:0] {
        SRC_BRANCH = 3'd0,
        SRC_MRET   = 3'd1,
        SRC_DRET   = 3'd2,
        SRC_EXC    = 3'd3,
        SRC_DEBUG  = 3'd4
    } redir_src_e;

    localparam int unsigned NUM_REDIR_SRC = 5;

endpackage

// File: rtl/pc_redirect_ctrl_prio_arb.sv
// Fixed-priority picker over eligibility-masked redirect requests.
// Latency: combinational, zero cycles.
// Backpressure: none; stateless, the caller decides when a winner is accepted.
module redirect_prio_arb
    import ibex_pkg::*;
#(
    parameter int unsigned N = NUM_REDIR_SRC
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] win
);

    logic taken;

    // Highest set index wins; at most one bit of win is set
    always_comb begin
        win   = '0;
        taken = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && !taken) begin
                win[i] = 1'b1;
                taken  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates redirect sources and drives the fetch-address mux.
// Latency: zero-cycle selection in RUN; a stalled winner is held in registers until accepted.
// Backpressure: fetch_ready_i low freezes the presented redirect (HOLD, busy_o=1), no preemption.
module pc_redirect_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned SquashCycles = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fetch_ready_i,
    input  logic       debug_req_i,
    input  logic       exc_req_i,
    input  logic       exc_is_irq_i,
    input  logic [6:0] exc_cause_i,
    input  logic       dret_req_i,
    input  logic       mret_req_i,
    input  logic       branch_req_i,
    output logic       pc_set_o,
    output logic [2:0] pc_mux_o,
    output logic [1:0] exc_pc_mux_o,
    output logic [6:0] exc_cause_o,
    output logic [4:0] grant_o,
    output logic       flush_o,
    output logic       debug_mode_o,
    output logic       busy_o
);

    localparam logic [3:0] SQUASH_LOAD = 4'(SquashCycles);

    redir_state_e state_q, state_d;
    logic         debug_mode_q;
    logic [3:0]   squash_cnt_q;

    pc_sel_e      hold_mux_q;
    exc_pc_sel_e  hold_exc_mux_q;
    exc_cause_t   hold_cause_q;
    logic [4:0]   hold_grant_q;

    logic [4:0]   req_masked;
    logic [4:0]   win;
    logic         any_win;
    logic         accept;
    logic         latch;

    pc_sel_e      sel_mux;
    exc_pc_sel_e  sel_exc_mux;
    exc_cause_t   sel_cause;

    // Eligibility masking ahead of the priority picker
    always_comb begin
        req_masked             = '0;
        req_masked[SRC_DEBUG]  = debug_req_i & ~debug_mode_q;
        req_masked[SRC_EXC]    = exc_req_i;
        req_masked[SRC_DRET]   = dret_req_i & debug_mode_q;
        req_masked[SRC_MRET]   = mret_req_i;
        req_masked[SRC_BRANCH] = branch_req_i & (squash_cnt_q == 4'd0);
    end

    redirect_prio_arb #(
        .N (NUM_REDIR_SRC)
    ) u_arb (
        .req (req_masked),
        .win (win)
    );

    assign any_win = |win;

    // Mux selections for the current winner
    always_comb begin
        sel_mux     = PC_BOOT;
        sel_exc_mux = EXC_PC_EXC;
        sel_cause   = '0;
        if (win[SRC_DEBUG]) begin
            sel_mux     = PC_EXC;
            sel_exc_mux = EXC_PC_DBD;
        end else if (win[SRC_EXC]) begin
            sel_mux   = PC_EXC;
            sel_cause = exc_cause_i;
            if (debug_mode_q) begin
                sel_exc_mux = EXC_PC_DBG_EXC;
            end else if (exc_is_irq_i) begin
                sel_exc_mux = EXC_PC_IRQ;
            end else begin
                sel_exc_mux = EXC_PC_EXC;
            end
        end else if (win[SRC_DRET]) begin
            sel_mux = PC_DRET;
        end else if (win[SRC_MRET]) begin
            sel_mux = PC_ERET;
        end else if (win[SRC_BRANCH]) begin
            sel_mux = PC_JUMP;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        pc_set_o     = 1'b0;
        pc_mux_o     = PC_BOOT;
        exc_pc_mux_o = EXC_PC_EXC;
        exc_cause_o  = '0;
        grant_o      = '0;
        busy_o       = 1'b0;
        accept       = 1'b0;
        latch        = 1'b0;
        case (state_q)
            BOOT: begin
                pc_set_o = 1'b1;
                busy_o   = 1'b1;
                if (fetch_ready_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                pc_set_o     = any_win;
                pc_mux_o     = sel_mux;
                exc_pc_mux_o = sel_exc_mux;
                exc_cause_o  = sel_cause;
                if (any_win) begin
                    if (fetch_ready_i) begin
                        grant_o = win;
                        accept  = 1'b1;
                    end else begin
                        busy_o  = 1'b1;
                        latch   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                pc_set_o     = 1'b1;
                pc_mux_o     = hold_mux_q;
                exc_pc_mux_o = hold_exc_mux_q;
                exc_cause_o  = hold_cause_q;
                if (fetch_ready_i) begin
                    grant_o = hold_grant_q;
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_o = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the stalled winner so HOLD presents it unchanged
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_mux_q     <= PC_BOOT;
            hold_exc_mux_q <= EXC_PC_EXC;
            hold_cause_q   <= '0;
            hold_grant_q   <= '0;
        end else if (latch) begin
            hold_mux_q     <= sel_mux;
            hold_exc_mux_q <= sel_exc_mux;
            hold_cause_q   <= sel_cause;
            hold_grant_q   <= win;
        end
    end

    // Squash window: reload on every accept, otherwise count down to zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            squash_cnt_q <= '0;
        end else if (accept) begin
            squash_cnt_q <= SQUASH_LOAD;
        end else if (squash_cnt_q != 4'd0) begin
            squash_cnt_q <= squash_cnt_q - 4'd1;
        end
    end

    // Debug mode: entered on debug grant, left on dret grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            debug_mode_q <= 1'b0;
        end else if (grant_o[SRC_DEBUG]) begin
            debug_mode_q <= 1'b1;
        end else if (grant_o[SRC_DRET]) begin
            debug_mode_q <= 1'b0;
        end
    end

    assign flush_o      = (squash_cnt_q != 4'd0);
    assign debug_mode_o = debug_mode_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with SquashCycles=2.
// Inputs driven 1ns after the rising edge, outputs sampled at the falling edge.
// All expectations are hand-derived constants.
module tb_pc_redirect_ctrl;

    localparam logic [2:0] M_BOOT = 3'd0;
    localparam logic [2:0] M_JUMP = 3'd1;
    localparam logic [2:0] M_EXC  = 3'd2;
    localparam logic [2:0] M_ERET = 3'd3;
    localparam logic [2:0] M_DRET = 3'd4;
    localparam logic [1:0] E_EXC  = 2'd0;
    localparam logic [1:0] E_IRQ  = 2'd1;
    localparam logic [1:0] E_DBD  = 2'd2;
    localparam logic [1:0] E_DBGX = 2'd3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       fetch_ready_i;
    logic       debug_req_i;
    logic       exc_req_i;
    logic       exc_is_irq_i;
    logic [6:0] exc_cause_i;
    logic       dret_req_i;
    logic       mret_req_i;
    logic       branch_req_i;
    logic       pc_set_o;
    logic [2:0] pc_mux_o;
    logic [1:0] exc_pc_mux_o;
    logic [6:0] exc_cause_o;
    logic [4:0] grant_o;
    logic       flush_o;
    logic       debug_mode_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl #(
        .SquashCycles (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_ready_i (fetch_ready_i),
        .debug_req_i   (debug_req_i),
        .exc_req_i     (exc_req_i),
        .exc_is_irq_i  (exc_is_irq_i),
        .exc_cause_i   (exc_cause_i),
        .dret_req_i    (dret_req_i),
        .mret_req_i    (mret_req_i),
        .branch_req_i  (branch_req_i),
        .pc_set_o      (pc_set_o),
        .pc_mux_o      (pc_mux_o),
        .exc_pc_mux_o  (exc_pc_mux_o),
        .exc_cause_o   (exc_cause_o),
        .grant_o       (grant_o),
        .flush_o       (flush_o),
        .debug_mode_o  (debug_mode_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Move from drive point to the falling-edge sample point
    task automatic settle();
        #4;
    endtask

    task automatic clear_reqs();
        debug_req_i  = 1'b0;
        exc_req_i    = 1'b0;
        exc_is_irq_i = 1'b0;
        exc_cause_i  = 7'h00;
        dret_req_i   = 1'b0;
        mret_req_i   = 1'b0;
        branch_req_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        fetch_ready_i = 1'b0;
        clear_reqs();
        #3;
        chk("rst_pc_set", 32'(pc_set_o), 32'd1);
        chk("rst_pc_mux", 32'(pc_mux_o), 32'(M_BOOT));
        chk("rst_exc_mux", 32'(exc_pc_mux_o), 32'(E_EXC));
        chk("rst_cause", 32'(exc_cause_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_dbg", 32'(debug_mode_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);

        // Boot: three not-ready cycles, then accepted; requests ignored
        repeat (2) @(posedge clk_i);
        #1;
        rst_i        = 1'b0;
        branch_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_ready_i = (i == 3);
            settle();
            chk("boot_pc_set", 32'(pc_set_o), 32'd1);
            chk("boot_pc_mux", 32'(pc_mux_o), 32'(M_BOOT));
            chk("boot_grant", 32'(grant_o), 32'd0);
            step();
        end
        branch_req_i = 1'b0;

        // Idle RUN
        fetch_ready_i = 1'b1;
        settle();
        chk("idle_pc_set", 32'(pc_set_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_mux", 32'(pc_mux_o), 32'(M_BOOT));
        step();

        // Branch accepted, then blocked for two squash cycles
        branch_req_i = 1'b1;
        settle();
        chk("br_mux", 32'(pc_mux_o), 32'(M_JUMP));
        chk("br_grant", 32'(grant_o), 32'h01);
        chk("br_flush0", 32'(flush_o), 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("sq_flush", 32'(flush_o), 32'd1);
            chk("sq_grant", 32'(grant_o), 32'd0);
            chk("sq_pc_set", 32'(pc_set_o), 32'd0);
            step();
        end
        settle();
        chk("br2_grant", 32'(grant_o), 32'h01);
        chk("br2_flush", 32'(flush_o), 32'd0);
        step();
        branch_req_i = 1'b0;
        step();
        step();
        settle();
        chk("sq_done", 32'(flush_o), 32'd0);
        step();

        // Exception + branch collide under stall; debug arrives while held
        exc_req_i     = 1'b1;
        exc_is_irq_i  = 1'b1;
        exc_cause_i   = 7'h0B;
        branch_req_i  = 1'b1;
        fetch_ready_i = 1'b0;
        settle();
        chk("col_mux", 32'(pc_mux_o), 32'(M_EXC));
        chk("col_emux", 32'(exc_pc_mux_o), 32'(E_IRQ));
        chk("col_cause", 32'(exc_cause_o), 32'h0B);
        chk("col_busy", 32'(busy_o), 32'd1);
        chk("col_grant", 32'(grant_o), 32'd0);
        step();
        debug_req_i  = 1'b1;
        exc_is_irq_i = 1'b0;
        exc_cause_i  = 7'h03;
        settle();
        chk("hold_mux", 32'(pc_mux_o), 32'(M_EXC));
        chk("hold_emux", 32'(exc_pc_mux_o), 32'(E_IRQ));
        chk("hold_cause", 32'(exc_cause_o), 32'h0B);
        chk("hold_busy", 32'(busy_o), 32'd1);
        chk("hold_grant", 32'(grant_o), 32'd0);
        step();
        fetch_ready_i = 1'b1;
        settle();
        chk("hold_acc_grant", 32'(grant_o), 32'h08);
        chk("hold_acc_cause", 32'(exc_cause_o), 32'h0B);
        step();
        exc_req_i    = 1'b0;
        branch_req_i = 1'b0;
        exc_cause_i  = 7'h00;
        settle();
        chk("dbg_mux", 32'(pc_mux_o), 32'(M_EXC));
        chk("dbg_emux", 32'(exc_pc_mux_o), 32'(E_DBD));
        chk("dbg_grant", 32'(grant_o), 32'h10);
        chk("dbg_mode_same", 32'(debug_mode_o), 32'd0);
        step();
        debug_req_i = 1'b0;
        settle();
        chk("dbg_mode_set", 32'(debug_mode_o), 32'd1);
        step();

        // Exception while in debug mode
        exc_req_i   = 1'b1;
        exc_cause_i = 7'h02;
        settle();
        chk("dx_emux", 32'(exc_pc_mux_o), 32'(E_DBGX));
        chk("dx_grant", 32'(grant_o), 32'h08);
        chk("dx_cause", 32'(exc_cause_o), 32'h02);
        step();
        exc_req_i   = 1'b0;
        exc_cause_i = 7'h00;
        debug_req_i = 1'b1;
        settle();
        chk("dx_mode", 32'(debug_mode_o), 32'd1);
        chk("dbg_ign_set", 32'(pc_set_o), 32'd0);
        chk("dbg_ign_grant", 32'(grant_o), 32'd0);
        step();
        debug_req_i = 1'b0;
        dret_req_i  = 1'b1;
        settle();
        chk("dret_mux", 32'(pc_mux_o), 32'(M_DRET));
        chk("dret_grant", 32'(grant_o), 32'h04);
        step();
        settle();
        chk("dret_mode", 32'(debug_mode_o), 32'd0);
        chk("dret_out_set", 32'(pc_set_o), 32'd0);
        chk("dret_out_grant", 32'(grant_o), 32'd0);
        step();
        dret_req_i = 1'b0;
        step();
        step();

        // MRET beats branch
        mret_req_i   = 1'b1;
        branch_req_i = 1'b1;
        settle();
        chk("mret_mux", 32'(pc_mux_o), 32'(M_ERET));
        chk("mret_grant", 32'(grant_o), 32'h02);
        step();
        mret_req_i   = 1'b0;
        branch_req_i = 1'b0;
        step();
        step();

        // Asynchronous reset while holding an MRET
        mret_req_i    = 1'b1;
        fetch_ready_i = 1'b0;
        step();
        settle();
        chk("rh_busy", 32'(busy_o), 32'd1);
        chk("rh_mux", 32'(pc_mux_o), 32'(M_ERET));
        #2;
        rst_i = 1'b1;
        #1;
        chk("rh_rst_mux", 32'(pc_mux_o), 32'(M_BOOT));
        chk("rh_rst_set", 32'(pc_set_o), 32'd1);
        chk("rh_rst_busy", 32'(busy_o), 32'd1);
        chk("rh_rst_flush", 32'(flush_o), 32'd0);
        step();
        rst_i         = 1'b0;
        mret_req_i    = 1'b0;
        fetch_ready_i = 1'b1;
        settle();
        chk("rh_boot_mux", 32'(pc_mux_o), 32'(M_BOOT));
        chk("rh_boot_grant", 32'(grant_o), 32'd0);
        step();
        settle();
        chk("rh_run_set", 32'(pc_set_o), 32'd0);
        chk("rh_run_grant", 32'(grant_o), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequencer for the fetch-address mux: arbitrates all PC-redirect requesters (debug entry, exception/IRQ, DRET, MRET, branch/jump).
- Drives pc_set / pc_mux / exc_pc_mux / exc_cause for the PC selection datapath and holds each redirect stable until fetch accepts it.
- Owns the boot sequence, debug-mode tracking, and the post-redirect squash window. Sits in the controller, between the ID/EX request sources and the IF stage.

Parameters:
- SquashCycles, 2: cycles flush_o stays high after an accepted redirect; branch requests are ignored during the window; range 0..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- fetch_ready_i  in  1  IF stage accepts the presented PC this cycle
- debug_req_i  in  1  enter debug mode
- exc_req_i  in  1  exception/IRQ redirect
- exc_is_irq_i  in  1  1 = interrupt, 0 = synchronous exception
- exc_cause_i  in  7  exc_cause_t of the request
- dret_req_i  in  1  return from debug
- mret_req_i  in  1  return from trap
- branch_req_i  in  1  taken branch/jump (target lives in the datapath)
- pc_set_o  out  1  redirect valid
- pc_mux_o  out  3  pc_sel_e
- exc_pc_mux_o  out  2  exc_pc_sel_e
- exc_cause_o  out  7  exc_cause_t forwarded to the ISR vector mux
- grant_o  out  5  one-hot accept pulse: [0] branch, [1] mret, [2] dret, [3] exc, [4] debug
- flush_o  out  1  squash wrong-path fetch
- debug_mode_o  out  1  core is in debug mode
- busy_o  out  1  redirect presented but not yet accepted

Behaviour:
- FSM states:
  - BOOT: reset state.
  - RUN
  - HOLD
- Reset values:
  - Outputs: pc_set_o=1, pc_mux_o=PC_BOOT, exc_pc_mux_o=EXC_PC_EXC, exc_cause_o=0, grant_o=0, flush_o=0, debug_mode_o=0, busy_o=1.
  - Internal: squash counter=0.
- BOOT:
  - Present PC_BOOT until fetch_ready_i=1. That cycle: grant_o=0, flush_o=0, go to RUN.
  - Requests arriving in BOOT are ignored.
- RUN, priority debug > exc > dret > mret > branch. Eligibility:
  - debug_req_i only when debug_mode_o=0.
  - dret_req_i only when debug_mode_o=1.
  - branch_req_i only when the squash counter is 0.
  - exc_req_i and mret_req_i are always eligible.
- RUN outputs (combinational, same cycle, zero latency) for the winner:
  - debug: PC_EXC / EXC_PC_DBD.
  - exc: PC_EXC, with exc_pc_mux = EXC_PC_DBG_EXC if debug_mode_o, else EXC_PC_IRQ if exc_is_irq_i, else EXC_PC_EXC. exc_cause_o = exc_cause_i; otherwise exc_cause_o = 0.
  - dret: PC_DRET.
  - mret: PC_ERET.
  - branch: PC_JUMP.
- Accept in RUN (winner present and fetch_ready_i=1):
  - grant_o pulses 1 cycle for the winner.
  - Squash counter loads SquashCycles; flush_o = (counter != 0), registered.
  - State stays RUN.
- Stall in RUN (winner present and fetch_ready_i=0):
  - Winner's selection is registered and the FSM goes to HOLD. busy_o=1.
- HOLD:
  - Outputs come from the registers, stable regardless of new requests. No preemption, including debug.
  - Requesters keep asserting; their requests are re-arbitrated only after the grant.
  - On fetch_ready_i=1: grant the held requester (its bit only), load the squash counter, return to RUN.
- Squash counter:
  - Decrements each cycle when nonzero; saturates at 0.
  - A new accept reloads it, even mid-window.
  - SquashCycles=0 means flush_o is never asserted and branches are never blocked.
- debug_mode_o:
  - Set on the debug grant cycle (visible the next cycle); cleared on the dret grant.
  - An exception granted in debug mode leaves debug_mode_o=1.
- Simultaneous exc_req_i and branch_req_i: exc wins; branch gets no grant.
- No request: pc_set_o=0, pc_mux_o=PC_BOOT (don't-care value, fixed for lint/equivalence), busy_o=0.
- Reset mid-HOLD: asynchronous return to BOOT with reset values; the pending request is dropped.
- Unknown state encoding: falls to BOOT.

Decomposition:
- ibex_pkg already provides pc_sel_e, exc_pc_sel_e, exc_cause_t.
- Add to ibex_pkg:
  - redir_state_e (BOOT, RUN, HOLD).
  - redir_src_e: one-hot grant bit indices, 5 entries.
- Natural sub-module: redirect_prio_arb, a combinational fixed-priority picker. It takes eligibility-masked requests and returns the one-hot winner.
- The FSM, hold registers, squash counter and debug-mode flag stay in the top module.

Test Plan:
- Boot: release reset with fetch_ready_i=0 for 3 cycles, then 1 -> pc_set_o=1, pc_mux_o=PC_BOOT for 4 cycles; grant_o=0; RUN afterward.
- Branch with SquashCycles=2: branch_req_i=1, fetch_ready_i=1 -> PC_JUMP same cycle, grant_o=5'b00001. flush_o=1 for the next 2 cycles. A branch_req_i issued in those cycles is not granted; the same request is granted in cycle 3.
- Collision and stall: exc_req_i=1 (irq, cause 7'h0B) + branch_req_i=1, fetch_ready_i=0 for 2 cycles. debug_req_i rises in cycle 1 -> outputs held at PC_EXC / EXC_PC_IRQ / 7'h0B, busy_o=1. On ready, grant_o=5'b01000. Debug is granted on the next ready cycle as PC_EXC / EXC_PC_DBD.
- Debug mode:
  - In debug mode: exc_req_i -> exc_pc_mux_o = EXC_PC_DBG_EXC, debug_mode_o stays 1.
  - debug_req_i is ignored.
  - dret_req_i -> PC_DRET, grant_o=5'b00100; debug_mode_o=0 the next cycle.
  - dret_req_i outside debug mode -> no pc_set_o.
- MRET vs branch: mret_req_i + branch_req_i same cycle -> PC_ERET, grant_o=5'b00010.
- Reset mid-HOLD: assert rst_i asynchronously mid-cycle while in HOLD -> outputs at reset values immediately; after release, BOOT sequence; the held request is never granted.
